// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - register offsets and edge-mode encodings for the PIO
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUT_RB   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_INFO     = 3'd6;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync_edge.sv
// rtl/soc_system_pio_sync_edge.sv - input synchroniser, arm counter and per-bit edge select
module soc_system_pio_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] sync_in,
  output logic [DATA_W-1:0] edge_pulse
);

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

  logic [DATA_W-1:0] stage [SYNC_STAGES];
  logic [DATA_W-1:0] prev;
  logic [CNT_W-1:0]  arm_cnt;
  logic              armed;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] fall;
  logic [DATA_W-1:0] sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      stage[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1];
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // Armed once both sync_in and prev carry samples taken after reset release
  assign armed   = (arm_cnt == CNT_W'(ARM_CYCLES));
  assign sync_in = stage[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev;
  assign fall    = ~sync_in & prev;
  assign sel     = (EDGE_MODE == EDGE_FALL) ? fall :
                   (EDGE_MODE == EDGE_ANY)  ? (rise | fall) : rise;
  assign edge_pulse = armed ? sel : '0;

endmodule

// File: rtl/soc_system_pio_edge_irq.sv
// rtl/soc_system_pio_edge_irq.sv - Avalon-MM PIO with edge capture, maskable irq and out set/clear aliases
module soc_system_pio_edge_irq
  import soc_system_pio_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                SYNC_STAGES = 2,
  parameter int                EDGE_MODE   = EDGE_RISE,
  parameter logic [DATA_W-1:0] OUT_RESET   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] sync_in;
  logic [DATA_W-1:0] edge_pulse;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] irq_mask;
  logic [DATA_W-1:0] edge_cap;
  logic [DATA_W-1:0] w1c;
  logic              wr;
  logic              unused_ok;

  soc_system_pio_sync_edge #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_MODE   (EDGE_MODE)
  ) u_sync_edge (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_W-1:0];
  assign unused_ok = ^writedata;
  assign w1c       = (wr && address == ADDR_EDGE_CAP) ? wd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg  <= OUT_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      // A new edge overrides a clear aimed at the same bit in the same cycle
      edge_cap <= (edge_cap & ~w1c) | edge_pulse;
      if (wr) begin
        case (address)
          ADDR_DATA:     out_reg  <= wd;
          ADDR_IRQ_MASK: irq_mask <= wd;
          ADDR_OUTSET:   out_reg  <= out_reg | wd;
          ADDR_OUTCLR:   out_reg  <= out_reg & ~wd;
          default: ;
        endcase
      end
      case (address)
        ADDR_DATA:     readdata <= 32'(sync_in);
        ADDR_OUT_RB:   readdata <= 32'(out_reg);
        ADDR_IRQ_MASK: readdata <= 32'(irq_mask);
        ADDR_EDGE_CAP: readdata <= 32'(edge_cap);
        ADDR_INFO:     readdata <= {16'h0, 8'(SYNC_STAGES), 8'(DATA_W)};
        default:       readdata <= '0;
      endcase
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// tb/tb_soc_system_pio_edge_irq.sv - scoreboard bench for three edge-mode builds of the PIO
module tb_soc_system_pio_edge_irq;

  localparam int         S       = 2;
  localparam logic [7:0] OUT_RST = 8'h3C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'h0;
  logic [7:0]  in_port = 8'h00;
  logic [31:0] rd   [3];
  logic [7:0]  outp [3];
  logic        irq  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    soc_system_pio_edge_irq #(
      .DATA_W(8), .SYNC_STAGES(S), .EDGE_MODE(g), .OUT_RESET(OUT_RST)
    ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[g]),
      .in_port(in_port), .out_port(outp[g]), .irq(irq[g])
    );
  end

  // Reference model: pin samples since reset, and register contents per mode
  logic [7:0]        hist [$];
  logic [7:0]        m_out;
  logic [7:0]        m_mask;
  logic [7:0]        m_cap [3];
  logic              m_init = 1'b0;
  logic [2:0][31:0]  exp_q [$];
  int                tests = 0;
  int                fails = 0;

  function automatic logic [31:0] model_read(input logic [2:0] a, input logic [7:0] s, input int k);
    case (a)
      3'd0:    return {24'h0, s};
      3'd1:    return {24'h0, m_out};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap[k]};
      3'd6:    return 32'h0000_0208;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [2:0][31:0] e;
    logic [7:0] snew, sold, rise, fall, clr, wd;
    int n;
    if (reset) begin
      hist.delete();
      m_out  = OUT_RST;
      m_mask = 8'h00;
      for (int k = 0; k < 3; k++) m_cap[k] = 8'h00;
      m_init = 1'b1;
      exp_q.push_back('0);
    end else if (m_init) begin
      n    = hist.size();
      snew = (n >= S) ? hist[n-S] : 8'h00;
      for (int k = 0; k < 3; k++) e[k] = model_read(address, snew, k);
      exp_q.push_back(e);
      wd   = writedata[7:0];
      clr  = (chipselect && !write_n && address == 3'd3) ? wd : 8'h00;
      rise = 8'h00;
      fall = 8'h00;
      if (n >= S + 1) begin
        sold = hist[n-S-1];
        rise = snew & ~sold;
        fall = ~snew & sold;
      end
      m_cap[0] = (m_cap[0] & ~clr) | rise;
      m_cap[1] = (m_cap[1] & ~clr) | fall;
      m_cap[2] = (m_cap[2] & ~clr) | rise | fall;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out  = wd;
          3'd2: m_mask = wd;
          3'd4: m_out  = m_out | wd;
          3'd5: m_out  = m_out & ~wd;
          default: ;
        endcase
      end
      hist.push_back(in_port);
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s mode%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0][31:0] e;
    if (m_init) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) check("readdata", k, rd[k], e[k]);
      end
      for (int k = 0; k < 3; k++) begin
        check("irq", k, 32'(irq[k]), 32'(|(m_cap[k] & m_mask)));
        check("out_port", k, 32'(outp[k]), 32'(m_out));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_op(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_op(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  initial begin
    in_port = 8'hFF;
    reset   = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(6);
    rd_op(3'd0); rd_op(3'd6); rd_op(3'd3); rd_op(3'd7);

    wr_op(3'd0, 32'hFFFF_FFA5); wr_op(3'd4, 32'h0A); wr_op(3'd5, 32'h81);
    rd_op(3'd4); rd_op(3'd5); rd_op(3'd1);

    in_port = 8'h00; idle(5);
    wr_op(3'd3, 32'hFF); wr_op(3'd2, 32'h01);
    in_port = 8'h09; idle(5);
    rd_op(3'd3); wr_op(3'd3, 32'h01); rd_op(3'd3); idle(2);

    wr_op(3'd3, 32'hFF);
    in_port[2] = 1'b1; idle(2);
    wr_op(3'd3, 32'h04); rd_op(3'd3);

    in_port = 8'h00; idle(5); wr_op(3'd3, 32'hFF);
    in_port[5] = 1'b1; idle(5);
    in_port[5] = 1'b0; idle(5);
    rd_op(3'd3); wr_op(3'd2, 32'h20); idle(2);

    wr_op(3'd2, 32'hFF);
    in_port = 8'hFF; idle(5);
    in_port = 8'h00; idle(5);
    rd_op(3'd3);
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h55;
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd_op(3'd1); rd_op(3'd2); idle(4);

    repeat (2500) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom & $urandom & $urandom);
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
